// File: rtl/posit8_pkg.sv
// rtl/posit8_pkg.sv - shared posit8 constants and the unpacked-field record
package posit8_pkg;

  localparam int          POSIT_N    = 8;
  localparam logic [7:0]  POSIT_ZERO = 8'h00;
  localparam logic [7:0]  POSIT_NAR  = 8'h80;
  localparam int          SCALE_W    = 7;
  // Widest mantissa ({hidden, fraction}) over the legal ES range (ES=0 gives 1+5).
  localparam int          MANT_MAX_W = 6;

  typedef struct packed {
    logic                  sign;
    logic                  zero;
    logic                  nar;
    logic [SCALE_W-1:0]    scale;
    logic [MANT_MAX_W-1:0] mant;   // right-aligned {1'b1, fraction}
  } posit8_unpacked_t;

endpackage

// File: rtl/posit8_regime_count.sv
// rtl/posit8_regime_count.sv - combinational regime run-length counter on 7 magnitude bits
module posit8_regime_count (
  input  logic [6:0] bits_i,
  output logic [6:0] k_o,
  output logic [2:0] r_o
);

  logic [2:0] run;
  logic       stop;

  // Count how many bits from the MSB match the leading regime bit; 7 means no terminator.
  always_comb begin
    run  = 3'd1;
    stop = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (!stop && (bits_i[i] == bits_i[6])) begin
        run = run + 3'd1;
      end else begin
        stop = 1'b1;
      end
    end
  end

  assign r_o = run;
  // A run of ones encodes k = r-1, a run of zeros encodes k = -r.
  assign k_o = bits_i[6] ? ({4'd0, run} - 7'd1) : (7'd0 - {4'd0, run});

endmodule

// File: rtl/posit8_unpack.sv
// rtl/posit8_unpack.sv - pipelined posit8 unpacker; POSIT8_UNPACK_OUTREG_EN adds a third output register stage
module posit8_unpack
  import posit8_pkg::*;
#(
  parameter int ES     = 2,
  parameter int FRAC_W = 5 - ES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [POSIT_N-1:0] in_posit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic               out_zero,
  output logic               out_nar,
  output logic [SCALE_W-1:0] out_scale,
  output logic [FRAC_W:0]    out_mant
);

  // ---------------- S1: sign, magnitude, regime ----------------
  logic       s1_valid_q;
  logic       s1_sign_q, s1_zero_q, s1_nar_q;
  logic [6:0] s1_k_q, s1_k_d;
  logic [2:0] s1_r_q, s1_r_d;
  logic [6:0] s1_mag_q, s1_mag_d;
  logic       s1_load, s2_load;

  // Negative posits are decoded from their two's complement; only the low 7 bits matter.
  assign s1_mag_d = in_posit[7] ? 7'(~in_posit + 8'd1) : in_posit[6:0];

  posit8_regime_count u_regime (
    .bits_i (s1_mag_d),
    .k_o    (s1_k_d),
    .r_o    (s1_r_d)
  );

  // A stage refills when empty or when its current entry moves downstream this cycle.
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // S1 register: captures the regime decode of the accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s1_k_q     <= '0;
      s1_r_q     <= '0;
      s1_mag_q   <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= in_posit[7];
        s1_zero_q <= (in_posit == POSIT_ZERO);
        s1_nar_q  <= (in_posit == POSIT_NAR);
        s1_k_q    <= s1_k_d;
        s1_r_q    <= s1_r_d;
        s1_mag_q  <= s1_mag_d;
      end
    end
  end

  // ---------------- S2: exponent / fraction extraction ----------------
  logic               s2_valid_q;
  logic               s2_sign_q, s2_zero_q, s2_nar_q;
  logic [SCALE_W-1:0] s2_scale_q, s2_scale_d;
  logic [FRAC_W:0]    s2_mant_q, s2_mant_d;
  logic [2:0]         shamt;
  logic [4:0]         fields;
  logic [1:0]         e_val;

  // Drop the regime and its terminator; the 5 bits left hold ES exponent bits then the fraction.
  assign shamt  = (s1_r_q == 3'd7) ? 3'd7 : (s1_r_q + 3'd1);
  assign fields = 5'((s1_mag_q << shamt) >> 2);
  assign e_val  = 2'(fields >> (5 - ES));

  // Special values carry no magnitude fields.
  always_comb begin
    s2_scale_d = (s1_k_q << ES) + {5'd0, e_val};
    s2_mant_d  = {1'b1, fields[FRAC_W-1:0]};
    if (s1_zero_q || s1_nar_q) begin
      s2_scale_d = '0;
      s2_mant_d  = '0;
    end
  end

`ifdef POSIT8_UNPACK_OUTREG_EN
  logic s3_valid_q, s3_load;
  assign s3_load = !s3_valid_q || out_ready;
  assign s2_load = !s2_valid_q || s3_load;
`else
  assign s2_load = !s2_valid_q || out_ready;
`endif

  // S2 register: holds extracted fields until the next stage (or the consumer) takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_nar_q   <= 1'b0;
      s2_scale_q <= '0;
      s2_mant_q  <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_q  <= s1_sign_q;
        s2_zero_q  <= s1_zero_q;
        s2_nar_q   <= s1_nar_q;
        s2_scale_q <= s2_scale_d;
        s2_mant_q  <= s2_mant_d;
      end
    end
  end

`ifdef POSIT8_UNPACK_OUTREG_EN
  // ---------------- S3: optional output register ----------------
  logic               s3_sign_q, s3_zero_q, s3_nar_q;
  logic [SCALE_W-1:0] s3_scale_q;
  logic [FRAC_W:0]    s3_mant_q;

  // S3 register: outputs driven straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      s3_sign_q  <= 1'b0;
      s3_zero_q  <= 1'b0;
      s3_nar_q   <= 1'b0;
      s3_scale_q <= '0;
      s3_mant_q  <= '0;
    end else if (s3_load) begin
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_sign_q  <= s2_sign_q;
        s3_zero_q  <= s2_zero_q;
        s3_nar_q   <= s2_nar_q;
        s3_scale_q <= s2_scale_q;
        s3_mant_q  <= s2_mant_q;
      end
    end
  end

  assign out_valid = s3_valid_q;
  assign out_sign  = s3_sign_q;
  assign out_zero  = s3_zero_q;
  assign out_nar   = s3_nar_q;
  assign out_scale = s3_scale_q;
  assign out_mant  = s3_mant_q;
`else
  assign out_valid = s2_valid_q;
  assign out_sign  = s2_sign_q;
  assign out_zero  = s2_zero_q;
  assign out_nar   = s2_nar_q;
  assign out_scale = s2_scale_q;
  assign out_mant  = s2_mant_q;
`endif

endmodule

// File: tb/tb_posit8_unpack.sv
// tb/tb_posit8_unpack.sv - randomized scoreboard bench for posit8_unpack
module tb_posit8_unpack;
  import posit8_pkg::*;

  localparam int ES     = 2;
  localparam int FRAC_W = 5 - ES;
`ifdef POSIT8_UNPACK_OUTREG_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif
  localparam int LAT = DEPTH;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic [7:0]         in_posit;
  logic               out_sign, out_zero, out_nar;
  logic [SCALE_W-1:0] out_scale;
  logic [FRAC_W:0]    out_mant;

  posit8_unpack #(.ES(ES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_nar   (out_nar),
    .out_scale (out_scale),
    .out_mant  (out_mant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Decode straight from the posit definition with integer arithmetic.
  function automatic posit8_unpacked_t model(input logic [7:0] p);
    posit8_unpacked_t u;
    int mag, lead, r, k, sh, nrem, rest, padded, e, frac;
    u = '0;
    u.sign = p[7];
    if (p == 8'h00) begin u.zero = 1'b1; return u; end
    if (p == 8'h80) begin u.nar  = 1'b1; return u; end
    mag  = (p[7] ? (256 - int'(p)) : int'(p)) % 128;
    lead = (mag >> 6) & 1;
    r = 0;
    while (r < 7 && ((mag >> (6 - r)) & 1) == lead) r++;
    k      = lead ? (r - 1) : -r;
    sh     = (r + 1 > 7) ? 7 : r + 1;
    nrem   = 7 - sh;
    rest   = mag & ((1 << nrem) - 1);
    padded = rest << (5 - nrem);
    e      = padded >> FRAC_W;
    frac   = padded & ((1 << FRAC_W) - 1);
    u.scale = 7'(k * (1 << ES) + e);
    u.mant  = 6'((1 << FRAC_W) | frac);
    return u;
  endfunction

  posit8_unpacked_t exp_q[$];
  int               acc_q[$];
  int               cyc = 0;
  int               occ = 0;
  int               pop_cnt = 0;
  int               last_lat = 0;
  posit8_unpacked_t act_last;
  logic             hold_pending = 1'b0;
  int               held_vec = 0;

  function automatic int out_vec();
    return int'({out_valid, out_sign, out_zero, out_nar, out_scale, out_mant});
  endfunction

  // Inputs are set at the negedge by the caller; this samples, scores and advances one cycle.
  task automatic cycle(output logic accepted);
    posit8_unpacked_t ex;
    #1;
    check("in_ready_vs_occupancy", in_ready, int'((occ < DEPTH) || out_ready));
    if (hold_pending) check("hold_stable", out_vec(), held_vec);
    accepted = in_valid && in_ready;
    if (accepted) begin
      exp_q.push_back(model(in_posit));
      acc_q.push_back(cyc);
      occ++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        ex = exp_q.pop_front();
        last_lat = cyc - acc_q.pop_front();
        check("sign",  out_sign, ex.sign);
        check("zero",  out_zero, ex.zero);
        check("nar",   out_nar,  ex.nar);
        check("scale", $signed(out_scale), $signed(ex.scale));
        check("mant",  out_mant, ex.mant);
        if (last_lat < LAT) check("latency_min", last_lat, LAT);
        act_last = '{out_sign, out_zero, out_nar, out_scale, 6'(out_mant)};
        pop_cnt++;
        occ--;
      end
    end
    hold_pending = out_valid && !out_ready;
    held_vec = out_vec();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send_one(input logic [7:0] p);
    logic a;
    int start;
    start = pop_cnt;
    in_valid = 1'b1; in_posit = p; out_ready = 1'b1;
    cycle(a);
    in_valid = 1'b0;
    for (int n = 0; n < 10 && pop_cnt == start; n++) cycle(a);
    check("result_arrived", int'(pop_cnt != start), 1);
    check("latency_exact", last_lat, LAT);
  endtask

  initial begin
    logic a;
    logic saw_stall;
    int   idx, start;
    logic [7:0] words [4];
    words[0] = 8'h40; words[1] = 8'h52; words[2] = 8'h7F; words[3] = 8'h01;

    rst_n = 1'b0; in_valid = 1'b0; in_posit = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_data", int'({out_sign, out_zero, out_nar, out_scale, out_mant}), 0);
    rst_n = 1'b1;

    // Directed values from the posit definition, ES = 2.
    send_one(8'h40);
    check("x40_sign", act_last.sign, 0);
    check("x40_scale", $signed(act_last.scale), 0);
    check("x40_mant", act_last.mant, 8);
    send_one(8'h52);
    check("x52_scale", $signed(act_last.scale), 2);
    check("x52_mant", act_last.mant, 10);
    send_one(8'hC0);
    check("xC0_sign", act_last.sign, 1);
    check("xC0_scale", $signed(act_last.scale), 0);
    check("xC0_mant", act_last.mant, 8);
    send_one(8'h7F);
    check("x7F_scale", $signed(act_last.scale), 24);
    check("x7F_mant", act_last.mant, 8);
    send_one(8'h01);
    check("x01_scale", $signed(act_last.scale), -24);
    check("x01_mant", act_last.mant, 8);
    send_one(8'h00);
    check("x00_zero", act_last.zero, 1);
    check("x00_nar", act_last.nar, 0);
    check("x00_scale", $signed(act_last.scale), 0);
    check("x00_mant", act_last.mant, 0);
    send_one(8'h80);
    check("x80_nar", act_last.nar, 1);
    check("x80_zero", act_last.zero, 0);
    check("x80_sign", act_last.sign, 1);

    // Back-to-back stream with the consumer stalled for cycles 2..5.
    idx = 0; saw_stall = 1'b0; start = pop_cnt;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 2 && c <= 5);
      in_valid  = (idx < 4);
      in_posit  = words[idx % 4];
      #1;
      if (in_valid && !in_ready) saw_stall = 1'b1;
      #0;
      cycle(a);
      if (a) idx++;
    end
    in_valid = 1'b0;
    check("bp_in_ready_dropped", saw_stall, 1);
    check("bp_all_accepted", idx, 4);
    check("bp_all_delivered", pop_cnt - start, 4);

    // Reset with two entries in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    in_posit = 8'h52; cycle(a);
    in_posit = 8'h7F; cycle(a);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete(); acc_q.delete(); occ = 0; hold_pending = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) cycle(a);
    send_one(8'h40);
    check("post_rst_scale", $signed(act_last.scale), 0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 15))
        0:       in_posit = 8'h00;
        1:       in_posit = 8'h80;
        2:       in_posit = 8'h7F;
        3:       in_posit = 8'h81;
        default: in_posit = 8'($urandom);
      endcase
      cycle(a);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) cycle(a);
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
